bsg_dly_lock_ctrl: RTL

Digital lock controller for the delay line. It closes the loop between a synchronized phase-detector sample stream and the delay-line control code. Each iteration waits for the line to settle, majority-votes a window of phase samples, then steps the code by one LSB. It declares lock once the decisions dither around the target. It sits beside the delay-line and monitor tag clients; `en_i` and `init_code_i` are driven from tag-programmed registers.

---
 rtl/bsg_dly_lock_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bsg_dly_lock_ctrl.sv
// bsg_dly_lock_ctrl: settle / majority-vote / single-LSB step loop that locks a delay-line code
module bsg_dly_lock_ctrl #(
   parameter int code_width_p    = 8,
   parameter int settle_cycles_p = 16,
   parameter int sample_count_p  = 8,
   parameter int lock_toggles_p  = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    en_i,
   input  logic [code_width_p-1:0] init_code_i,
   input  logic                    early_i,
   input  logic                    valid_i,
   output logic [code_width_p-1:0] dly_code_o,
   output logic                    code_update_o,
   output logic                    locked_o,
   output logic                    sat_o,
   output logic                    busy_o
);
   localparam int sw_lp = $clog2(settle_cycles_p+1);
   localparam int nw_lp = $clog2(sample_count_p+1);
   localparam int tw_lp = $clog2(lock_toggles_p+1);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_e;
   typedef enum logic [1:0] {NONE, UP, DN} dir_e;
   state_e                  state_q, state_d;
   dir_e                    prev_q, prev_d;
   logic [code_width_p-1:0] code_q, code_d;
   logic                    upd_q, upd_d, locked_q, locked_d, sat_q, sat_d;
   logic [sw_lp-1:0]        settle_q, settle_d;
   logic [nw_lp-1:0]        smp_q, smp_d, early_q, early_d;
   logic [tw_lp-1:0]        tog_q, tog_d, tog_n;
   logic                    up, dn, opp, sat_hit;
   assign up      = early_q > nw_lp'(sample_count_p/2);
   assign dn      = early_q < nw_lp'(sample_count_p/2);
   assign sat_hit = (up & (&code_q)) | (dn & ~|code_q);
   assign opp     = (up & prev_q == DN) | (dn & prev_q == UP);
   // ties and reversals both count as dithering; a repeated direction restarts the count
   assign tog_n   = (!up && !dn) || opp
                    ? (tog_q == tw_lp'(lock_toggles_p) ? tog_q : tog_q + tw_lp'(1))
                    : '0;
   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      code_d   = code_q;
      upd_d    = 1'b0;
      locked_d = locked_q;
      sat_d    = sat_q;
      settle_d = settle_q;
      smp_d    = smp_q;
      early_d  = early_q;
      tog_d    = tog_q;
      unique case (state_q)
         IDLE: if (en_i) begin
            code_d   = init_code_i;
            upd_d    = 1'b1;
            prev_d   = NONE;
            tog_d    = '0;
            settle_d = sw_lp'(settle_cycles_p);
            state_d  = SETTLE;
         end
         SETTLE: begin
            settle_d = settle_q - sw_lp'(1);
            if (settle_q == sw_lp'(1)) begin
               state_d = SAMPLE;
               smp_d   = '0;
               early_d = '0;
            end
         end
         SAMPLE: if (valid_i) begin
            smp_d   = smp_q + nw_lp'(1);
            early_d = early_q + nw_lp'(early_i);
            state_d = smp_q == nw_lp'(sample_count_p-1) ? DECIDE : SAMPLE;
         end
         DECIDE: begin
            state_d  = SETTLE;
            settle_d = sw_lp'(settle_cycles_p);
            code_d   = sat_hit ? code_q
                     : up ? code_q + code_width_p'(1)
                     : dn ? code_q - code_width_p'(1) : code_q;
            upd_d    = (up | dn) & ~sat_hit;
            sat_d    = sat_hit;
            prev_d   = up ? UP : dn ? DN : prev_q;
            tog_d    = tog_n;
            locked_d = tog_n == tw_lp'(lock_toggles_p);
         end
         default: state_d = IDLE;
      endcase
      // dropping enable wins over any decision taken in the same cycle
      if (!en_i && state_q != IDLE) begin
         state_d  = IDLE;
         code_d   = code_q;
         upd_d    = 1'b0;
         locked_d = 1'b0;
         sat_d    = 1'b0;
         settle_d = '0;
         smp_d    = '0;
         early_d  = '0;
         tog_d    = '0;
         prev_d   = NONE;
      end
   end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         prev_q   <= NONE;
         code_q   <= '0;
         upd_q    <= 1'b0;
         locked_q <= 1'b0;
         sat_q    <= 1'b0;
         settle_q <= '0;
         smp_q    <= '0;
         early_q  <= '0;
         tog_q    <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         code_q   <= code_d;
         upd_q    <= upd_d;
         locked_q <= locked_d;
         sat_q    <= sat_d;
         settle_q <= settle_d;
         smp_q    <= smp_d;
         early_q  <= early_d;
         tog_q    <= tog_d;
      end
   end
   assign dly_code_o    = code_q;
   assign code_update_o = upd_q;
   assign locked_o      = locked_q;
   assign sat_o         = sat_q;
   assign busy_o        = state_q != IDLE;
endmodule
